// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle for uart_rx_cfg: serial input, consumer ready, and the held frame.
// master = the receiver that produces frames, slave = the consumer that drives the line and ready.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_i;
  logic                 ready_i;
  logic                 valid_o;
  logic [DATA_BITS-1:0] data_o;
  logic                 parity_err_o;
  logic                 frame_err_o;
  logic                 overrun_o;

  modport master (
    input  rx_i, ready_i,
    output valid_o, data_o, parity_err_o, frame_err_o, overrun_o
  );
  modport slave (
    output rx_i, ready_i,
    input  valid_o, data_o, parity_err_o, frame_err_o, overrun_o
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, optional parity, 1-2 stop bits,
// single-entry output holding register with overrun pulse.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input logic           clk_i,
  input logic           reset_i,
  uart_rx_cfg_if.master bus
);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_n;
  logic                 frame_acc, frame_acc_n;
  logic                 done;
  logic                 sync1, rxs, rxs_q;

  logic                 valid_q, perr_q, ferr_q, ovr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 perr_c;

  // rxs_q is the previous synchronized sample, used only for falling-edge detect
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      sync1 <= bus.rx_i;
      rxs   <= sync1;
      rxs_q <= rxs;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      frame_acc <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      par_bit   <= par_n;
      frame_acc <= frame_acc_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_n       = bit_cnt;
    shreg_n     = shreg;
    par_n       = par_bit;
    frame_acc_n = frame_acc;
    done        = 1'b0;
    unique case (state)
      S_IDLE: if (rxs_q && !rxs) begin
        cnt_n   = '0;
        state_n = S_START;
      end
      S_START: if (cnt == HALF_M1) begin
        cnt_n       = '0;
        bit_n       = '0;
        frame_acc_n = 1'b0;
        state_n     = rxs ? S_IDLE : S_DATA;
      end else cnt_n = cnt + CW'(1);
      S_DATA: if (cnt == FULL_M1) begin
        cnt_n   = '0;
        shreg_n = {rxs, shreg[DATA_BITS-1:1]};
        bit_n   = bit_cnt + 4'd1;
        if (bit_cnt == LAST_DATA) begin
          bit_n   = '0;
          state_n = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end else cnt_n = cnt + CW'(1);
      S_PARITY: if (cnt == FULL_M1) begin
        cnt_n   = '0;
        par_n   = rxs;
        state_n = S_STOP;
      end else cnt_n = cnt + CW'(1);
      S_STOP: if (cnt == FULL_M1) begin
        cnt_n       = '0;
        frame_acc_n = frame_acc | ~rxs;
        bit_n       = bit_cnt + 4'd1;
        if (bit_cnt == LAST_STOP) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end
      end else cnt_n = cnt + CW'(1);
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    perr_c = 1'b0;
    if (PARITY == 1) perr_c = ~(^shreg ^ par_bit);
    else if (PARITY == 2) perr_c = ^shreg ^ par_bit;
  end

  // A same-cycle accept frees the slot, so a completing frame may load over it
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (valid_q && bus.ready_i) valid_q <= 1'b0;
      if (done) begin
        if (!valid_q || bus.ready_i) begin
          valid_q <= 1'b1;
          data_q  <= shreg;
          perr_q  <= perr_c;
          ferr_q  <= frame_acc | ~rxs;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.data_o       = data_q;
  assign bus.parity_err_o = perr_q;
  assign bus.frame_err_o  = ferr_q;
  assign bus.overrun_o    = ovr_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: dut_a (no parity, 1 stop) and dut_b (even parity, 2 stops), both 16 clk/bit.
// Senders push expected frames; per-DUT monitors pop and compare on each accepted frame.
module tb_uart_rx_cfg;
  localparam int CPB = 16;
  localparam int GAP = 4;

  typedef struct { logic [7:0] d; logic pe; logic fe; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   ovr_cnt[2];
  int   start_cyc[2];
  int   rise_cyc[2];
  logic va_prev = 1'b0;
  logic vb_prev = 1'b0;

  uart_rx_cfg_if #(.DATA_BITS(8)) ifa ();
  uart_rx_cfg_if #(.DATA_BITS(8)) ifb ();

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.clk_i(clk), .reset_i(rst), .bus(ifa));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2))
    dut_b (.clk_i(clk), .reset_i(rst), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v);
    if (d == 0) ifa.rx_i = v;
    else        ifb.rx_i = v;
  endtask

  // Reference frame: start, 8 data LSB-first, even parity on dut_b, then stop bits
  task automatic send(input int d, input logic [7:0] data, input logic pbit,
                      input logic [1:0] stp, input bit push);
    exp_t e;
    int nstop;
    nstop = (d == 0) ? 1 : 2;
    e.d  = data;
    e.pe = (d == 1) ? (^data ^ pbit) : 1'b0;
    e.fe = (stp[0] == 1'b0) || (nstop == 2 && stp[1] == 1'b0);
    if (push) begin
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
    start_cyc[d] = cyc;
    drive(d, 1'b0); wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin drive(d, data[i]); wait_cyc(CPB); end
    if (d == 1) begin drive(d, pbit); wait_cyc(CPB); end
    for (int s = 0; s < nstop; s++) begin drive(d, stp[s]); wait_cyc(CPB); end
    drive(d, 1'b1);
    wait_cyc(GAP);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ifa.overrun_o) ovr_cnt[0]++;
      if (ifb.overrun_o) ovr_cnt[1]++;
      if (ifa.valid_o && !va_prev) rise_cyc[0] = cyc;
      if (ifb.valid_o && !vb_prev) rise_cyc[1] = cyc;
      if (ifa.valid_o && ifa.ready_i) begin
        if (qa.size() == 0) begin
          checks++;
          $display("FAIL a_unexpected_frame: got data %h, expected no frame", ifa.data_o);
        end else begin
          e = qa.pop_front();
          chk("a_frame", {22'd0, ifa.data_o, ifa.parity_err_o, ifa.frame_err_o}, {22'd0, e.d, e.pe, e.fe});
        end
      end
      if (ifb.valid_o && ifb.ready_i) begin
        if (qb.size() == 0) begin
          checks++;
          $display("FAIL b_unexpected_frame: got data %h, expected no frame", ifb.data_o);
        end else begin
          e = qb.pop_front();
          chk("b_frame", {22'd0, ifb.data_o, ifb.parity_err_o, ifb.frame_err_o}, {22'd0, e.d, e.pe, e.fe});
        end
      end
    end
    va_prev = ifa.valid_o;
    vb_prev = ifb.valid_o;
  end

  initial begin
    int ov0;
    ovr_cnt[0] = 0; ovr_cnt[1] = 0;
    ifa.rx_i = 1'b1; ifb.rx_i = 1'b1;
    ifa.ready_i = 1'b1; ifb.ready_i = 1'b1;
    wait_cyc(4);
    chk("a_reset_outputs", {20'd0, ifa.valid_o, ifa.data_o, ifa.parity_err_o, ifa.frame_err_o, ifa.overrun_o}, 32'd0);
    chk("b_reset_outputs", {20'd0, ifb.valid_o, ifb.data_o, ifb.parity_err_o, ifb.frame_err_o, ifb.overrun_o}, 32'd0);
    rst = 1'b0;
    wait_cyc(4);

    send(0, 8'hA5, 1'b0, 2'b11, 1'b1);
    chk("a_latency", rise_cyc[0] - start_cyc[0], CPB / 2 + 3 + 9 * CPB);

    send(1, 8'h3C, 1'b0, 2'b11, 1'b1);
    send(1, 8'h3C, 1'b1, 2'b11, 1'b1);
    send(0, 8'h55, 1'b0, 2'b10, 1'b1);
    send(1, 8'h55, 1'b0, 2'b01, 1'b1);

    // 5-cycle glitch, then a real frame launched at the latest point the FSM must accept it
    ifa.rx_i = 1'b0; wait_cyc(5);
    ifa.rx_i = 1'b1; wait_cyc(CPB / 2 + 1 - 5);
    send(0, 8'h96, 1'b0, 2'b11, 1'b1);

    // overrun: second frame dropped while the first is held
    ifa.ready_i = 1'b0;
    ov0 = ovr_cnt[0];
    send(0, 8'h11, 1'b0, 2'b11, 1'b1);
    send(0, 8'h22, 1'b0, 2'b11, 1'b0);
    wait_cyc(2);
    chk("a_overrun_pulses", ovr_cnt[0] - ov0, 1);
    chk("a_held_data", {23'd0, ifa.valid_o, ifa.data_o}, {23'd1, 8'h11});
    ifa.ready_i = 1'b1;
    wait_cyc(2);
    chk("a_valid_falls", {31'd0, ifa.valid_o}, 32'd0);

    // accept in the very cycle the next frame completes: no overrun, new frame loads
    ifa.ready_i = 1'b0;
    send(0, 8'h33, 1'b0, 2'b11, 1'b1);
    ov0 = ovr_cnt[0];
    fork
      send(0, 8'h44, 1'b0, 2'b11, 1'b1);
      begin
        wait_cyc(CPB / 2 + 2 + 9 * CPB);
        ifa.ready_i = 1'b1;
        wait_cyc(1);
        ifa.ready_i = 1'b0;
      end
    join
    wait_cyc(3);
    chk("a_same_cycle_no_overrun", ovr_cnt[0] - ov0, 0);
    chk("a_same_cycle_reload", {23'd0, ifa.valid_o, ifa.data_o}, {23'd1, 8'h44});
    ifa.ready_i = 1'b1;
    wait_cyc(2);

    // break: line low for several frame times gives exactly one framing-error frame
    qa.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
    ifa.rx_i = 1'b0; wait_cyc(CPB * 13);
    ifa.rx_i = 1'b1; wait_cyc(20);

    // reset mid-frame (after the 4th data bit of 0xF0) aborts with no output
    ifa.rx_i = 1'b0; wait_cyc(CPB);
    for (int i = 0; i < 4; i++) wait_cyc(CPB);
    ifa.rx_i = 1'b1; wait_cyc(CPB / 2);
    rst = 1'b1; wait_cyc(3);
    rst = 1'b0; wait_cyc(3 * CPB);
    chk("a_no_frame_after_reset", {31'd0, ifa.valid_o}, 32'd0);
    send(0, 8'h0F, 1'b0, 2'b11, 1'b1);

    for (int n = 0; n < 16; n++) begin
      logic [1:0] st;
      st[0] = ($urandom_range(0, 3) != 0);
      st[1] = ($urandom_range(0, 3) != 0);
      send(0, 8'($urandom), 1'b0, st, 1'b1);
      send(1, 8'($urandom), 1'($urandom), st, 1'b1);
    end

    wait_cyc(20);
    chk("a_all_frames_delivered", qa.size(), 0);
    chk("b_all_frames_delivered", qb.size(), 0);
    chk("b_no_overrun", ovr_cnt[1], 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
